cache_2way_wb: RTL and testbench
================================

# cache_2way_wb

Parametrised 2-way set-associative write-back, write-allocate data cache. It sits between the CPU memory stage and the AXI/bridge side, and replaces the fixed 16-set, 16-word cache. Sets and line length are set by parameters. Only dirty victims are written back, any byte-enable mask is accepted, and writeback and refill use explicit request/acknowledge handshakes. The CPU side sees single-cycle hits and a stall request on misses.

## Interface
- INDEX_W, default 4: set index bits; number of sets = 2^INDEX_W.
- OFFSET_W, default 4: word offset bits; words per line = 2^OFFSET_W; LINE_W = 32·2^OFFSET_W.
- Tag width TAG_W = 30 − INDEX_W − OFFSET_W (derived, not overridable).
- clk, in, 1: clock.
- rst, in, 1: reset, synchronous, active-high.
- en, in, 1: access valid this cycle.
- wen, in, 4: byte write enables; 0 = load.
- addr, in, 32: byte address; {tag, index, offset} = addr[31:2]; addr[1:0] ignored.
- wdata, in, 32: store data, byte lanes per wen.
- rdata, out, 32: load data, registered.
- stallreq, out, 1: CPU must hold en/wen/addr/wdata stable while high.
- wb_req, out, 1: dirty-line writeback request, level.
- wb_addr, out, 32: {victim_tag, index, OFFSET_W+2 zero bits}.
- wb_data, out, LINE_W: victim line.
- wb_done, in, 1: writeback accepted, 1-cycle pulse.
- rf_req, out, 1: refill request, level.
- rf_addr, out, 32: {tag_i, index, zeros}.
- rf_ack, in, 1: refill request accepted, pulse.
- rf_valid, in, 1: refill line present, pulse.
- rf_data, in, LINE_W: refill line; word k is at bits [32k+31:32k].

## Operation
- Per set: valid[2], dirty[2], tag[2], line[2], and one lru bit. lru is the victim way.
- Lookup is combinational in IDLE: hit_w = valid[w] && tag[w]==tag_i. Both ways hitting is impossible by construction.
- Hit in IDLE with en:
  - lru <= ~w.
  - Load: rdata <= word[offset] at the next edge.
  - Store: byte lane b written iff wen[b]; dirty[w] <= 1; rdata <= 0.
- rdata <= 0 on any cycle with !en, or with en and no hit. rdata holds its value while not in IDLE.
- Victim: the first invalid way (way0 if both are invalid); otherwise the way named by lru. Victim way and tag are latched on leaving IDLE.
- FSM states: IDLE, WB, RF_REQ, RF_WAIT.
  - IDLE: en && miss → WB if the victim is valid and dirty, else RF_REQ.
  - WB: wb_req=1, wb_addr/wb_data stable. On wb_done → RF_REQ.
  - RF_REQ: rf_req=1, rf_addr stable. On rf_ack → RF_WAIT.
  - RF_WAIT: on rf_valid, the victim way gets line=rf_data, tag=tag_i, valid=1, dirty=0; lru <= ~victim; → IDLE.
- After returning to IDLE the held access hits and completes normally; a store merges into the fresh line.
- stallreq = (state != IDLE) || (en && !hit). Combinational; 0 during rst.
- wb_done is ignored outside WB. rf_ack is ignored outside RF_REQ. rf_valid is ignored outside RF_WAIT; memory must not assert rf_valid in the same cycle as rf_ack.

## Timing
- Reset values: rdata=0, wb_req=0, wb_addr=0, wb_data=0, rf_req=0, rf_addr=0. All valid and dirty bits = 0, all lru = 0, state = IDLE.
- rst asserted mid-miss: at the next edge all requests drop, state = IDLE, and all lines are invalidated. Dirty data is discarded and no writeback is issued.
- Hit load: addr at cycle t, rdata valid after edge t+1, stallreq=0 throughout.
- Clean miss with zero-wait memory (rf_ack in the first RF_REQ cycle, rf_valid in the first RF_WAIT cycle):
  - stallreq is high for 3 cycles (miss, RF_REQ, RF_WAIT).
  - Cycle 4 hits; rdata appears at edge 4.
- Dirty miss adds ≥1 WB cycle before RF_REQ.
- wb_*/rf_* outputs are registered, change only on state entry, and stay stable until the matching handshake.

## Test plan
Parameters for all scenarios: INDEX_W=4, OFFSET_W=4. Address 0x1040 maps to tag 4, index 1. Refill line k = 0xA000_0000+k unless stated.

- Cold load 0x104C after reset:
  - stallreq=1, no wb_req, rf_req with rf_addr=0x0000_1040.
  - After refill, rdata=0xA000_0003 one cycle after stallreq falls.
- Store 0x104C, wen=4'b0010, wdata=0x0000_5500 → stallreq=0; a following load of 0x104C gives rdata=0xA000_5503.
- Load 0x1440 (fills way1), then load 0x1040 (hit), then load 0x1840:
  - The victim is way1, which is clean, so no wb_req.
  - rf_addr=0x0000_1840; the line lands in way1.
- Then load 0x1440:
  - The victim is way0, which is dirty, so wb_req=1 with wb_addr=0x0000_1040 and wb_data word3=0xA000_5503.
  - wb_req stays held until wb_done; then rf_req with rf_addr=0x0000_1440.
- Delay rf_ack 5 cycles and rf_valid 3 cycles → rf_req/rf_addr stable throughout, stallreq high throughout. A stray wb_done or early rf_valid has no effect.
- Assert rst while wb_req=1 → next edge: wb_req=0, rf_req=0, rdata=0. The next load of 0x104C misses and issues no writeback.

Source files
------------

// File: rtl/cache_2way_wb.sv
// cache_2way_wb: 2-way set-associative write-back, write-allocate data cache with
// single-cycle hits, dirty-only writeback and request/ack refill handshakes.
module cache_2way_wb #(
  parameter int INDEX_W = 4,
  parameter int OFFSET_W = 4,
  localparam int SETS = 1 << INDEX_W,
  localparam int LINE_W = 32 << OFFSET_W,
  localparam int TAG_W = 30 - INDEX_W - OFFSET_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [3:0]        wen,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              stallreq,
  output logic              wb_req,
  output logic [31:0]       wb_addr,
  output logic [LINE_W-1:0] wb_data,
  input  logic              wb_done,
  output logic              rf_req,
  output logic [31:0]       rf_addr,
  input  logic              rf_ack,
  input  logic              rf_valid,
  input  logic [LINE_W-1:0] rf_data
);
  typedef enum logic [1:0] {IDLE, WB, RF_REQ, RF_WAIT} state_t;
  state_t r_state, w_next;
  logic [SETS-1:0][1:0] r_valid, r_dirty;
  logic [SETS-1:0]      r_lru;
  logic [TAG_W-1:0]     r_tag [SETS][2];
  logic [LINE_W-1:0]    r_line [SETS][2];
  logic                 r_vic, r_wb_req, r_rf_req;
  logic [31:0]          r_rdata, r_wb_addr, r_rf_addr;
  logic [LINE_W-1:0]    r_wb_data;
  logic [TAG_W-1:0]     w_tag;
  logic [INDEX_W-1:0]   w_idx;
  logic [OFFSET_W-1:0]  w_off;
  logic [1:0]           w_hits;
  logic                 w_hit, w_way, w_vic, w_go, w_miss;
  assign w_tag = addr[31 -: TAG_W];
  assign w_idx = addr[OFFSET_W+2 +: INDEX_W];
  assign w_off = addr[2 +: OFFSET_W];
  assign w_hits = {r_valid[w_idx][1] && r_tag[w_idx][1] == w_tag,
                   r_valid[w_idx][0] && r_tag[w_idx][0] == w_tag};
  assign w_hit = |w_hits;
  assign w_way = w_hits[1];
  // fill an empty way before evicting anything
  assign w_vic = !r_valid[w_idx][0] ? 1'b0 : !r_valid[w_idx][1] ? 1'b1 : r_lru[w_idx];
  assign w_go = r_state == IDLE && en && w_hit;
  assign w_miss = r_state == IDLE && en && !w_hit;
  assign stallreq = !rst && (r_state != IDLE || (en && !w_hit));
  assign rdata = r_rdata;
  assign wb_req = r_wb_req;
  assign wb_addr = r_wb_addr;
  assign wb_data = r_wb_data;
  assign rf_req = r_rf_req;
  assign rf_addr = r_rf_addr;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_miss) w_next = r_valid[w_idx][w_vic] && r_dirty[w_idx][w_vic] ? WB : RF_REQ;
      WB:      if (wb_done) w_next = RF_REQ;
      RF_REQ:  if (rf_ack) w_next = RF_WAIT;
      RF_WAIT: if (rf_valid) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      r_state <= IDLE;
      r_wb_req <= 1'b0;
      r_rf_req <= 1'b0;
      r_rdata <= '0;
      r_wb_addr <= '0;
      r_wb_data <= '0;
      r_rf_addr <= '0;
    end else begin
      r_state <= w_next;
      r_wb_req <= w_next == WB;
      r_rf_req <= w_next == RF_REQ;
      if (r_state == IDLE) r_rdata <= w_go && wen == 4'd0 ? r_line[w_idx][w_way][{w_off, 5'd0} +: 32] : '0;
      if (w_miss) begin
        r_vic <= w_vic;
        r_wb_addr <= {r_tag[w_idx][w_vic], w_idx, {(OFFSET_W+2){1'b0}}};
        r_wb_data <= r_line[w_idx][w_vic];
        r_rf_addr <= {w_tag, w_idx, {(OFFSET_W+2){1'b0}}};
      end
    end
  always_ff @(posedge clk)
    if (rst) begin
      r_valid <= '0;
      r_dirty <= '0;
      r_lru <= '0;
    end else if (w_go) begin
      r_lru[w_idx] <= ~w_way;
      if (|wen) r_dirty[w_idx][w_way] <= 1'b1;
      for (int b = 0; b < 4; b++)
        if (wen[b]) r_line[w_idx][w_way][{w_off, b[1:0], 3'd0} +: 8] <= wdata[8*b +: 8];
    end else if (r_state == RF_WAIT && rf_valid) begin
      r_line[w_idx][r_vic] <= rf_data;
      r_tag[w_idx][r_vic] <= w_tag;
      r_valid[w_idx][r_vic] <= 1'b1;
      r_dirty[w_idx][r_vic] <= 1'b0;
      r_lru[w_idx] <= ~r_vic;
    end
endmodule

// File: tb/tb_cache_2way_wb.sv
// tb_cache_2way_wb: directed bench for cache_2way_wb with a handshake-driven memory
// responder and a queue of expected load results.
module tb_cache_2way_wb;
  logic         clk = 1'b0;
  logic         rst, en;
  logic [3:0]   wen;
  logic [31:0]  addr, wdata, rdata;
  logic         stallreq, wb_req, wb_done, rf_req, rf_ack, rf_valid;
  logic [31:0]  wb_addr, rf_addr;
  logic [511:0] wb_data, rf_data;
  int checks = 0, errors = 0;
  int wb_dly, ack_dly, val_dly, stray;
  int wcnt = 0, rcnt = 0, vcnt = 0, waiting = 0;
  int wb_cnt = 0, wb_hi = 0, rf_hi = 0, wb_unstable = 0, rf_unstable = 0;
  logic [31:0] rf_base, cap_wb_addr, cap_wb_w3, cap_rf_addr;
  logic [31:0] exp_q[$];
  string tag_q[$];

  cache_2way_wb #(.INDEX_W(4), .OFFSET_W(4)) dut (
    .clk(clk), .rst(rst), .en(en), .wen(wen), .addr(addr), .wdata(wdata), .rdata(rdata),
    .stallreq(stallreq), .wb_req(wb_req), .wb_addr(wb_addr), .wb_data(wb_data), .wb_done(wb_done),
    .rf_req(rf_req), .rf_addr(rf_addr), .rf_ack(rf_ack), .rf_valid(rf_valid), .rf_data(rf_data)
  );

  always #5 clk = ~clk;

  always_comb
    for (int k = 0; k < 16; k++) rf_data[32*k +: 32] = rf_base + 32'(k);

  // memory side: reacts on the falling edge so the DUT sees stable handshakes
  always @(negedge clk) begin
    wb_done = 1'b0;
    rf_ack = 1'b0;
    rf_valid = 1'b0;
    if (wb_req) begin
      if (wcnt == 0) begin
        wb_cnt++;
        cap_wb_addr = wb_addr;
        cap_wb_w3 = wb_data[127:96];
      end else if (wb_addr !== cap_wb_addr || wb_data[127:96] !== cap_wb_w3) wb_unstable = 1;
      wb_hi++;
      if (wcnt == wb_dly) wb_done = 1'b1;
      else if (stray != 0) rf_valid = 1'b1;
      wcnt++;
    end else wcnt = 0;
    if (rf_req) begin
      if (rcnt == 0) cap_rf_addr = rf_addr;
      else if (rf_addr !== cap_rf_addr) rf_unstable = 1;
      if (!stallreq) rf_unstable = 1;
      rf_hi++;
      if (rcnt == ack_dly) begin
        rf_ack = 1'b1;
        waiting = 1;
        vcnt = 0;
      end else if (stray != 0) begin
        rf_valid = 1'b1;
        wb_done = 1'b1;
      end
      rcnt++;
    end else begin
      rcnt = 0;
      if (waiting != 0) begin
        if (vcnt == val_dly) begin
          rf_valid = 1'b1;
          waiting = 0;
        end else if (stray != 0) begin
          rf_ack = 1'b1;
          wb_done = 1'b1;
        end
        vcnt++;
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic access(input string tag, input logic [31:0] a, input logic [3:0] we,
                        input logic [31:0] wd, input logic [31:0] exp_rd, input int exp_stall);
    int n = 0;
    en = 1'b1;
    addr = a;
    wen = we;
    wdata = wd;
    exp_q.push_back(exp_rd);
    tag_q.push_back(tag);
    #1;
    while (stallreq === 1'b1 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "_stall"}, 32'(n), 32'(exp_stall));
    @(posedge clk);
    #1;
    check(tag_q.pop_front(), rdata, exp_q.pop_front());
    en = 1'b0;
    wen = 4'd0;
  endtask

  initial begin
    int n, wb0;
    rst = 1'b1; en = 1'b1; addr = 32'h104C; wen = 4'd0; wdata = '0;
    wb_dly = 0; ack_dly = 0; val_dly = 0; stray = 0; rf_base = 32'hA000_0000;
    tick;
    tick;
    check("rst_rdata", rdata, 32'd0);
    check("rst_stall", 32'(stallreq), 32'd0);
    check("rst_wb_req", 32'(wb_req), 32'd0);
    check("rst_rf_req", 32'(rf_req), 32'd0);
    check("rst_wb_addr", wb_addr, 32'd0);
    check("rst_rf_addr", rf_addr, 32'd0);
    rst = 1'b0; en = 1'b0;
    tick;
    access("cold_load", 32'h104C, 4'd0, 32'd0, 32'hA000_0003, 3);
    check("cold_no_wb", 32'(wb_cnt), 32'd0);
    check("cold_rf_addr", cap_rf_addr, 32'h0000_1040);
    access("store_hit", 32'h104C, 4'b0010, 32'h0000_5500, 32'd0, 0);
    access("load_merged", 32'h104C, 4'd0, 32'd0, 32'hA000_5503, 0);
    rf_base = 32'hB000_0000;
    access("fill_way1", 32'h1440, 4'd0, 32'd0, 32'hB000_0000, 3);
    check("fill_way1_rf_addr", cap_rf_addr, 32'h0000_1440);
    access("hit_way0", 32'h1040, 4'd0, 32'd0, 32'hA000_0000, 0);
    rf_base = 32'hC000_0000;
    access("clean_victim", 32'h1840, 4'd0, 32'd0, 32'hC000_0000, 3);
    check("clean_no_wb", 32'(wb_cnt), 32'd0);
    check("clean_rf_addr", cap_rf_addr, 32'h0000_1840);
    access("hit_new_way1", 32'h1844, 4'd0, 32'd0, 32'hC000_0001, 0);
    wb_dly = 2; ack_dly = 5; val_dly = 3; stray = 1; rf_base = 32'hD000_0000;
    wb_hi = 0; rf_hi = 0;
    access("dirty_victim", 32'h1440, 4'd0, 32'd0, 32'hD000_0000, 14);
    check("dirty_wb_cnt", 32'(wb_cnt), 32'd1);
    check("dirty_wb_addr", cap_wb_addr, 32'h0000_1040);
    check("dirty_wb_word3", cap_wb_w3, 32'hA000_5503);
    check("dirty_wb_cycles", 32'(wb_hi), 32'd3);
    check("dirty_wb_stable", 32'(wb_unstable), 32'd0);
    check("dirty_rf_addr", cap_rf_addr, 32'h0000_1440);
    check("dirty_rf_cycles", 32'(rf_hi), 32'd6);
    check("dirty_rf_stable", 32'(rf_unstable), 32'd0);
    wb_dly = 0; ack_dly = 0; val_dly = 0; stray = 0;
    access("store_way0", 32'h1440, 4'hF, 32'h1234_5678, 32'd0, 0);
    access("store_way1", 32'h1840, 4'hF, 32'h8765_4321, 32'd0, 0);
    access("load_way1", 32'h1844, 4'd0, 32'd0, 32'hC000_0001, 0);
    wb_dly = 1_000_000;
    en = 1'b1; addr = 32'h104C; wen = 4'd0;
    n = 0;
    while (wb_req !== 1'b1 && n < 20) begin
      tick;
      n++;
    end
    check("mid_wb_req", 32'(wb_req), 32'd1);
    check("mid_wb_addr", wb_addr, 32'h0000_1440);
    rst = 1'b1;
    tick;
    check("midrst_wb_req", 32'(wb_req), 32'd0);
    check("midrst_rf_req", 32'(rf_req), 32'd0);
    check("midrst_rdata", rdata, 32'd0);
    check("midrst_stall", 32'(stallreq), 32'd0);
    rst = 1'b0; en = 1'b0; wb_dly = 0;
    tick;
    wb0 = wb_cnt;
    rf_base = 32'hA000_0000;
    access("after_rst", 32'h104C, 4'd0, 32'd0, 32'hA000_0003, 3);
    rf_base = 32'hE000_0000;
    access("after_rst_inval", 32'h1840, 4'd0, 32'd0, 32'hE000_0000, 3);
    check("after_rst_no_wb", 32'(wb_cnt), 32'(wb0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
